// File: rtl/draw_rect_fill_if.sv
// Datapath instruction bus: one plot instruction per start_dp/finished_dp handshake.
interface draw_rect_fill_if #(
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 32
);
  logic                start_dp;
  logic [INSTR_W-1:0]  instruction_dp;
  logic                finished_dp;
  logic [RESULT_W-1:0] result_dp;

  modport master (output start_dp, output instruction_dp, input finished_dp, input result_dp);
  modport slave  (input start_dp, input instruction_dp, output finished_dp, output result_dp);
endinterface

// File: rtl/draw_rect_fill.sv
// Rectangle-fill sequencer: walks a latched rectangle row-major, clips to the screen and
// dispatches one plot instruction per visible pixel to the shared drawing datapath.
module draw_rect_fill #(
  parameter int         X_W      = 8,
  parameter int         Y_W      = 7,
  parameter int         COLOUR_W = 3,
  parameter int         INSTR_W  = 32,
  parameter int         RESULT_W = 32,
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter logic [3:0] OPCODE   = 4'd1
)(
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W:0]        rect_w,
  input  logic [Y_W:0]        rect_h,
  input  logic [COLOUR_W-1:0] colour_a,
  input  logic [COLOUR_W-1:0] colour_b,
  input  logic [1:0]          mode,
  output logic                finished,
  output logic [15:0]         pix_count,
  draw_rect_fill_if.master    dp
);
  localparam int PAD_W = INSTR_W - 5 - COLOUR_W - Y_W - X_W;
  // Screen bounds held two bits wider than a coordinate so origin+offset never wraps.
  localparam logic [X_W+1:0] SCR_W = (X_W+2)'(SCREEN_W);
  localparam logic [Y_W+1:0] SCR_H = (Y_W+2)'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [X_W:0]        w;
    logic [Y_W:0]        h;
    logic [COLOUR_W-1:0] a;
    logic [COLOUR_W-1:0] b;
    logic [1:0]          mode;
  } rect_t;

  state_t         state;
  rect_t          r;
  logic [X_W:0]   cx, nx_cx;
  logic [Y_W:0]   cy, nx_cy;
  logic           abort_pend;

  logic [X_W+1:0]      px;
  logic [Y_W+1:0]      py;
  logic                on_screen, last_x, last_y, done;
  logic [COLOUR_W-1:0] colour;
  logic [INSTR_W-1:0]  instr_c;

  logic [RESULT_W-1:0] unused_result;
  assign unused_result = dp.result_dp;

  always_comb begin
    px        = {2'b00, r.x} + {1'b0, cx};
    py        = {2'b00, r.y} + {1'b0, cy};
    on_screen = (px < SCR_W) && (py < SCR_H);
    last_x    = (cx == r.w - 1'b1);
    last_y    = (cy == r.h - 1'b1);
    done      = last_x && last_y;
    nx_cx     = last_x ? '0 : cx + 1'b1;
    nx_cy     = last_x ? cy + 1'b1 : cy;
    colour    = r.a;
    unique case (r.mode)
      2'd0: colour = r.a;
      2'd1: colour = (cx[0] ^ cy[0]) ? r.b : r.a;
      2'd2: colour = cy[0] ? r.b : r.a;
      2'd3: colour = cx[0] ? r.b : r.a;
    endcase
    instr_c = {OPCODE, {PAD_W{1'b0}}, 1'b1, colour, py[Y_W-1:0], px[X_W-1:0]};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state             <= S_IDLE;
      finished          <= 1'b1;
      pix_count         <= '0;
      dp.start_dp       <= 1'b0;
      dp.instruction_dp <= '0;
      r                 <= '0;
      cx                <= '0;
      cy                <= '0;
      abort_pend        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            r          <= '{x: rect_x, y: rect_y, w: rect_w, h: rect_h,
                            a: colour_a, b: colour_b, mode: mode};
            cx         <= '0;
            cy         <= '0;
            pix_count  <= '0;
            abort_pend <= 1'b0;
            if (rect_w != '0 && rect_h != '0) begin
              finished <= 1'b0;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            finished <= 1'b1;
            state    <= S_IDLE;
          end else if (on_screen) begin
            dp.start_dp       <= 1'b1;
            dp.instruction_dp <= instr_c;
            pix_count         <= pix_count + 16'd1;
            state             <= S_HOLD;
          end else begin
            // Clipped pixel: one cycle, no strobe.
            cx <= nx_cx;
            cy <= nx_cy;
            if (done) begin
              finished <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (abort) abort_pend <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          dp.start_dp <= 1'b0;
          if (abort) abort_pend <= 1'b1;
          if (dp.finished_dp) begin
            cx <= nx_cx;
            cy <= nx_cy;
            if (done || abort_pend || abort) begin
              finished <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_rect_fill.sv
// Directed bench for draw_rect_fill: table of fills with hand-computed instruction streams,
// plus reset, abort and slow-datapath sequences.
module tb_draw_rect_fill;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  rect_x = '0;
  logic [6:0]  rect_y = '0;
  logic [8:0]  rect_w = '0;
  logic [7:0]  rect_h = '0;
  logic [2:0]  colour_a = '0;
  logic [2:0]  colour_b = '0;
  logic [1:0]  mode = '0;
  logic        finished;
  logic [15:0] pix_count;

  draw_rect_fill_if #(.INSTR_W(32), .RESULT_W(32)) dp();

  draw_rect_fill dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .colour_a(colour_a), .colour_b(colour_b), .mode(mode),
    .finished(finished), .pix_count(pix_count), .dp(dp)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int c);
    return {4'd1, 9'd0, 1'b1, 3'(c), 7'(y), 8'(x)};
  endfunction

  // Strobe monitor: records the instruction at each rising start_dp, and the strobe width.
  logic [31:0] got[$];
  int          bad_runs = 0;
  int          run = 0;
  logic        prev_sd = 1'b0;
  always @(negedge clock) begin
    if (dp.start_dp === 1'b1 && !prev_sd) got.push_back(dp.instruction_dp);
    if (dp.start_dp === 1'b1) run++;
    else if (run != 0) begin
      if (run != 2) bad_runs++;
      run = 0;
    end
    prev_sd = (dp.start_dp === 1'b1);
  end

  typedef struct {
    logic [7:0] x; logic [6:0] y; logic [8:0] w; logic [7:0] h;
    logic [2:0] a; logic [2:0] b; logic [1:0] mode;
    int n; int cyc; logic [3:0][31:0] e;
  } vec_t;

  vec_t tv[8];

  task automatic set_vec(input int i, input int x, input int y, input int w, input int h,
                         input int a, input int b, input int m, input int n, input int cyc,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    tv[i].x = 8'(x); tv[i].y = 7'(y); tv[i].w = 9'(w); tv[i].h = 8'(h);
    tv[i].a = 3'(a); tv[i].b = 3'(b); tv[i].mode = 2'(m);
    tv[i].n = n; tv[i].cyc = cyc;
    tv[i].e[0] = e0; tv[i].e[1] = e1; tv[i].e[2] = e2; tv[i].e[3] = e3;
  endtask

  // Present a fill for one cycle, then scramble the inputs to show they were latched.
  task automatic start_fill(input logic [7:0] x, input logic [6:0] y, input logic [8:0] w,
                            input logic [7:0] h, input logic [2:0] a, input logic [2:0] b,
                            input logic [1:0] m);
    @(negedge clock);
    rect_x = x; rect_y = y; rect_w = w; rect_h = h;
    colour_a = a; colour_b = b; mode = m; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    rect_x = 8'd77; rect_y = 7'd33; rect_w = 9'd5; rect_h = 8'd5;
    colour_a = 3'd7; colour_b = 3'd7; mode = 2'd3;
  endtask

  task automatic wait_idle(input string name, output int cyc);
    cyc = 0;
    while (finished !== 1'b1 && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 300) chk({name, "_timeout"}, 32'(finished), 32'd1);
  endtask

  initial begin
    int cyc;
    int n0;
    dp.finished_dp = 1'b1;
    dp.result_dp   = '0;

    set_vec(0, 10, 5, 2, 2, 2, 5, 0, 4, 12, mk(10,5,2), mk(11,5,2), mk(10,6,2), mk(11,6,2));
    set_vec(1, 158, 0, 4, 1, 7, 0, 0, 2, 8, mk(158,0,7), mk(159,0,7), 32'd0, 32'd0);
    set_vec(2, 0, 0, 2, 2, 1, 6, 1, 4, 12, mk(0,0,1), mk(1,0,6), mk(0,1,6), mk(1,1,1));
    set_vec(3, 0, 0, 2, 2, 1, 6, 2, 4, 12, mk(0,0,1), mk(1,0,1), mk(0,1,6), mk(1,1,6));
    set_vec(4, 4, 118, 2, 3, 3, 4, 3, 4, 14, mk(4,118,3), mk(5,118,4), mk(4,119,3), mk(5,119,4));
    set_vec(5, 20, 20, 0, 9, 1, 2, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_vec(6, 200, 0, 3, 2, 1, 2, 0, 0, 6, 32'd0, 32'd0, 32'd0, 32'd0);
    set_vec(7, 5, 5, 5, 0, 1, 2, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);

    repeat (3) @(negedge clock);
    chk("rst_finished", 32'(finished), 32'd1);
    chk("rst_start_dp", 32'(dp.start_dp), 32'd0);
    chk("rst_instr", dp.instruction_dp, 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      got.delete();
      bad_runs = 0;
      start_fill(tv[i].x, tv[i].y, tv[i].w, tv[i].h, tv[i].a, tv[i].b, tv[i].mode);
      wait_idle($sformatf("v%0d", i), cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tv[i].cyc));
      chk($sformatf("v%0d_n_instr", i), 32'(got.size()), 32'(tv[i].n));
      chk($sformatf("v%0d_pix_count", i), 32'(pix_count), 32'(tv[i].n));
      chk($sformatf("v%0d_strobe_width", i), 32'(bad_runs), 32'd0);
      for (int k = 0; k < tv[i].n; k++)
        chk($sformatf("v%0d_instr%0d", i, k), (got.size() > k) ? got[k] : 32'hdead_beef, tv[i].e[k]);
      @(negedge clock);
    end

    // Reset while waiting on the datapath.
    dp.finished_dp = 1'b0;
    got.delete();
    start_fill(8'd10, 7'd5, 9'd2, 8'd2, 3'd2, 3'd5, 2'd0);
    cyc = 0;
    while (!(got.size() > 0 && dp.start_dp === 1'b0) && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("rstmid_reached_wait", 32'(got.size()), 32'd1);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("rstmid_finished", 32'(finished), 32'd1);
    chk("rstmid_start_dp", 32'(dp.start_dp), 32'd0);
    chk("rstmid_instr", dp.instruction_dp, 32'd0);
    chk("rstmid_pix_count", 32'(pix_count), 32'd0);
    resetn = 1'b1;
    dp.finished_dp = 1'b1;
    n0 = got.size();
    repeat (10) @(negedge clock);
    chk("rstmid_no_more_strobes", 32'(got.size()), 32'(n0));
    chk("rstmid_still_idle", 32'(finished), 32'd1);

    // Abort seen in the first ISSUE cycle: nothing dispatched.
    got.delete();
    @(negedge clock);
    rect_x = 8'd0; rect_y = 7'd0; rect_w = 9'd2; rect_h = 8'd2; mode = 2'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_issue_finished", 32'(finished), 32'd1);
    repeat (5) @(negedge clock);
    chk("abort_issue_n_instr", 32'(got.size()), 32'd0);
    chk("abort_issue_pix_count", 32'(pix_count), 32'd0);

    // Slow datapath with abort during WAIT: one pixel, then back to idle.
    dp.finished_dp = 1'b0;
    got.delete();
    bad_runs = 0;
    start_fill(8'd0, 7'd0, 9'd3, 8'd1, 3'd5, 3'd2, 2'd0);
    repeat (4) @(negedge clock);
    chk("slow_wait_start_dp", 32'(dp.start_dp), 32'd0);
    chk("slow_wait_busy", 32'(finished), 32'd0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (2) @(negedge clock);
    chk("slow_still_waiting", 32'(finished), 32'd0);
    dp.finished_dp = 1'b1;
    @(negedge clock);
    dp.finished_dp = 1'b0;
    chk("slow_abort_finished", 32'(finished), 32'd1);
    chk("slow_abort_pix_count", 32'(pix_count), 32'd1);
    repeat (6) @(negedge clock);
    chk("slow_abort_n_instr", 32'(got.size()), 32'd1);
    chk("slow_abort_instr0", (got.size() > 0) ? got[0] : 32'hdead_beef, mk(0,0,5));
    chk("slow_strobe_width", 32'(bad_runs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
